serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor: D = A - B - BIN, with a borrow-out.
- It is the inverse-direction companion to the team's ripple-carry adder.
- One full-subtractor cell is reused LSB-first, one bit per clock, under a start/done handshake.
- Used where area matters more than latency, and as a cross-check against the adder (A + B + C0 vs. S - B - BIN).

Parameters:
- WIDTH, 4, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- A  input  WIDTH  minuend; sampled on the accepted start.
- B  input  WIDTH  subtrahend; sampled on the accepted start.
- BIN  input  1  borrow-in; sampled on the accepted start.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse when D/BOUT are updated.
- D  output  WIDTH  difference; registered, holds until the next done.
- BOUT  output  1  borrow-out; registered, holds until the next done.
- OVF  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, D=0, BOUT=0, OVF=0; internal shift registers, borrow flop and bit counter cleared.
- Reset mid-operation: the operation is aborted, no done is produced, and D/BOUT return to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1: latch A->a_sh, B->b_sh, BIN->br, set cnt=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy=1), each cycle:
  - d = a_sh[0] ^ b_sh[0] ^ br
  - br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br)
  - a_sh and b_sh shift right by 1.
  - d enters r_sh at the MSB; r_sh shifts right.
  - br <= br_next; cnt <= cnt + 1.
  - When cnt == WIDTH-1: D <= final r_sh (including this cycle's bit), BOUT <= br_next, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0.
  - start=1 in this cycle is accepted exactly as in IDLE and goes to RUN.
  - Otherwise go to IDLE.
- Latency: start accepted at edge N -> done high in the cycle after edge N+WIDTH. For WIDTH=4, done is asserted 5 cycles after start.
- Throughput: one result per WIDTH+1 cycles (back-to-back starts in DONE).
- start while busy=1 is ignored. No queueing, and the in-flight operands are unaffected.
- A, B and BIN may change freely after the accepting edge.
- D and BOUT change only on the edge that enters DONE (or on reset). They are stable at all other times, including during a subsequent RUN.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - BOUT=1 iff A < B + BIN (full-precision compare).
  - Equivalence: {~BOUT, D} == A + ~B + ~BIN (WIDTH+1 bits).
- cnt width is clog2(WIDTH); there is no wrap-around in normal operation, because cnt is reset on each accept.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Output OVF is present, registered and updated with D at DONE.
  - OVF = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]), using the latched operand sign bits (stored at accept).
  - OVF resets to 0 and holds between dones.
- Undefined:
  - OVF port and its sign-bit flops are absent.
  - All other behaviour is identical.

Test Plan:
- A=0011, B=0011, BIN=0, pulse start -> busy for 4 cycles; done on the 5th cycle after start; D=0000, BOUT=0.
- A=1011, B=0111, BIN=1 -> D=0011, BOUT=0. Then A=0011, B=0111, BIN=0 -> D=1100, BOUT=1.
- A=0000, B=1111, BIN=1 -> D=0000, BOUT=1. Then A=1111, B=0000, BIN=0 -> D=1111, BOUT=0.
- Start held high continuously with new operands on each accept -> results every 5 cycles. Start pulses and operand changes during RUN are ignored, and D/BOUT hold their previous values until each done.
- Assert rst for one cycle at the 2nd RUN cycle -> busy=0, no done, D=0, BOUT=0. A new start then completes normally.
- With SERIAL_SUB_OVF_EN: A=0111, B=1111, BIN=0 -> D=1000, OVF=1. A=0101, B=0011 -> D=0010, OVF=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor D = A - B - BIN with borrow-out
// Optional signed-overflow output OVF is built only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             busy,
  output logic             done,
`ifdef SERIAL_SUB_OVF_EN
  output logic             OVF,
`endif
  output logic [WIDTH-1:0] D,
  output logic             BOUT
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;

  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_sh_next;
  logic             w_last;

  // Full-subtractor cell on the current LSBs, plus the result shift-in.
  assign w_d       = r_a_sh[0] ^ r_b_sh[0] ^ r_br;
  assign w_br_next = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_br);
  assign w_sh_next = {w_d, r_sh[WIDTH-1:1]};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;
  logic w_ovf_next;

  // On the last bit, w_d is the MSB of the difference.
  assign w_ovf_next = (r_a_msb != r_b_msb) && (w_d != r_a_msb);
  assign OVF        = r_ovf;

  // Sign-bit capture at accept and overflow update on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if ((r_state != S_RUN) && start) begin
        r_a_msb <= A[WIDTH-1];
        r_b_msb <= B[WIDTH-1];
      end
      if ((r_state == S_RUN) && w_last) begin
        r_ovf <= w_ovf_next;
      end
    end
  end
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign D    = r_d;
  assign BOUT = r_bout;

  // Control FSM and datapath: accept in IDLE/DONE, one bit per cycle in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sh    <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_d     <= '0;
      r_bout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a_sh  <= A;
            r_b_sh  <= B;
            r_br    <= BIN;
            r_cnt   <= '0;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_RUN: begin
          r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_sh   <= w_sh_next;
          r_br   <= w_br_next;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_d     <= w_sh_next;
            r_bout  <= w_br_next;
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (WIDTH=4)
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BIN;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         BOUT;
`ifdef SERIAL_SUB_OVF_EN
  logic         OVF;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic [W-1:0] prev_d;
  logic         prev_bout;
  logic         prev_ovf;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .BIN   (BIN),
    .busy  (busy),
    .done  (done),
`ifdef SERIAL_SUB_OVF_EN
    .OVF   (OVF),
`endif
    .D     (D),
    .BOUT  (BOUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ovf(input string tag, input logic exp);
`ifdef SERIAL_SUB_OVF_EN
    chk(tag, 32'(OVF), 32'(exp));
`endif
  endtask

  // Caller is one step past an edge with the DUT in IDLE or DONE; returns in DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] exp_d, input logic exp_bout, input logic exp_ovf,
                        input logic keep_start, input string tag);
    A = a; B = b; BIN = bin; start = 1'b1;
    tick();
    for (int i = 0; i < W; i++) begin
      A = W'($urandom_range(15));
      B = W'($urandom_range(15));
      BIN = 1'($urandom_range(1));
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " done_low"}, 32'(done), 32'd0);
      chk({tag, " d_hold"}, 32'(D), 32'(prev_d));
      chk({tag, " bout_hold"}, 32'(BOUT), 32'(prev_bout));
      chk_ovf({tag, " ovf_hold"}, prev_ovf);
      start = keep_start || (i == 1);
      tick();
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy_low"}, 32'(busy), 32'd0);
    chk({tag, " D"}, 32'(D), 32'(exp_d));
    chk({tag, " BOUT"}, 32'(BOUT), 32'(exp_bout));
    chk_ovf({tag, " OVF"}, exp_ovf);
    prev_d = exp_d; prev_bout = exp_bout; prev_ovf = exp_ovf;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; BIN = 1'b0;
    prev_d = '0; prev_bout = 1'b0; prev_ovf = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset D", 32'(D), 32'd0);
    chk("reset BOUT", 32'(BOUT), 32'd0);
    chk_ovf("reset OVF", 1'b0);
    tick();

    run_op(4'b0011, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, "v1");
    tick();
    chk("v1 done_pulse_end", 32'(done), 32'd0);
    run_op(4'b1011, 4'b0111, 1'b1, 4'b0011, 1'b0, 1'b1, 1'b0, "v2");
    tick();
    run_op(4'b0011, 4'b0111, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0, "v3");
    tick();
    run_op(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, "v4");
    tick(); tick();
    run_op(4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, "v5");

    // Back-to-back accepts in DONE with start held high throughout.
    run_op(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b1, "b2b1");
    run_op(4'b0101, 4'b0110, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b1, "b2b2");
    run_op(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, "b2b3");
    run_op(4'b1010, 4'b0011, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0, "b2b4");
    tick();
    chk("b2b idle busy", 32'(busy), 32'd0);
    chk("b2b idle done", 32'(done), 32'd0);

    // Reset on the second RUN cycle aborts the operation.
    A = 4'b1001; B = 4'b0010; BIN = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("abort busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort D", 32'(D), 32'd0);
    chk("abort BOUT", 32'(BOUT), 32'd0);
    chk_ovf("abort OVF", 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("abort no_done", 32'(done), 32'd0);
      chk("abort idle", 32'(busy), 32'd0);
      tick();
    end
    prev_d = '0; prev_bout = 1'b0; prev_ovf = 1'b0;

    run_op(4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b0, "ovf1");
    tick();
    run_op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, "ovf0");
    tick();
    chk("final done", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
